// File: rtl/sop_sweep_pkg.sv
// Shared types and constants for the SOP sweep controller.
package sop_sweep_pkg;
    localparam int unsigned   NUM_VEC     = 16;
    localparam logic [15:0]   GOLDEN_MASK = 16'h4644;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } state_e;
endpackage

// File: rtl/sop_sweep_ctrl_if.sv
// Control/result bundle between the lab top-level and the sweep controller.
interface sop_sweep_ctrl_if;
    import sop_sweep_pkg::*;

    logic                 start;
    logic [NUM_VEC-1:0]   exp_mask;
    logic [3:0]           pqrs;
    logic                 busy;
    logic                 done;
    logic [NUM_VEC-1:0]   result;
    logic                 match;
    logic [4:0]           err_cnt;
    logic [3:0]           first_err_idx;

    modport master (
        output start, exp_mask,
        input  pqrs, busy, done, result, match, err_cnt, first_err_idx
    );

    modport slave (
        input  start, exp_mask,
        output pqrs, busy, done, result, match, err_cnt, first_err_idx
    );
endinterface

// File: rtl/sop_sweep_ctrl_eval.sv
// Gate-level evaluator for t = p q' r' s + r s'.
module sop_eval (
    input  logic p,
    input  logic q,
    input  logic r,
    input  logic s,
    output logic t
);
    logic term_a;
    logic term_b;

    assign term_a = p & ~q & ~r & s;
    assign term_b = r & ~s;
    assign t      = term_a | term_b;
endmodule

// File: rtl/sop_sweep_ctrl.sv
// Sweeps all 16 {p,q,r,s} vectors through sop_eval, captures the truth table
// and scores it against a mask latched at start.
module sop_sweep_ctrl
    import sop_sweep_pkg::*;
#(
    parameter int unsigned SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    sop_sweep_ctrl_if.slave  bus
);
    localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);
    localparam logic [3:0] LAST_VEC  = 4'(NUM_VEC - 1);

    state_e               state_q, state_d;
    logic [3:0]           pqrs_q, pqrs_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [NUM_VEC-1:0]   mask_q, mask_d;
    logic [NUM_VEC-1:0]   result_q, result_d;
    logic                 match_q, match_d;
    logic [4:0]           err_q, err_d;
    logic [3:0]           ferr_q, ferr_d;
    logic                 t;
    logic                 miss;

    sop_eval u_eval (
        .p (pqrs_q[3]),
        .q (pqrs_q[2]),
        .r (pqrs_q[1]),
        .s (pqrs_q[0]),
        .t (t)
    );

    assign miss = (t != mask_q[pqrs_q]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pqrs_q   <= '0;
            cnt_q    <= '0;
            mask_q   <= '0;
            result_q <= '0;
            match_q  <= 1'b0;
            err_q    <= '0;
            ferr_q   <= '0;
        end else begin
            state_q  <= state_d;
            pqrs_q   <= pqrs_d;
            cnt_q    <= cnt_d;
            mask_q   <= mask_d;
            result_q <= result_d;
            match_q  <= match_d;
            err_q    <= err_d;
            ferr_q   <= ferr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pqrs_d   = pqrs_q;
        cnt_d    = cnt_q;
        mask_d   = mask_q;
        result_d = result_q;
        match_d  = match_q;
        err_d    = err_q;
        ferr_d   = ferr_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    result_d = '0;
                    err_d    = '0;
                    ferr_d   = '0;
                    match_d  = 1'b0;
                    mask_d   = bus.exp_mask;
                    pqrs_d   = '0;
                    cnt_d    = '0;
                    state_d  = DRIVE;
                end
            end
            DRIVE: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == SETTLE_M1) state_d = SAMPLE;
            end
            SAMPLE: begin
                result_d[pqrs_q] = t;
                if (miss) begin
                    err_d = err_q + 5'd1;
                    if (err_q == '0) ferr_d = pqrs_q;
                end
                if (pqrs_q == LAST_VEC) begin
                    // Score on entry to DONE so match is already valid while done is high.
                    match_d = (err_d == '0);
                    state_d = DONE;
                end else begin
                    pqrs_d  = pqrs_q + 4'd1;
                    cnt_d   = '0;
                    state_d = DRIVE;
                end
            end
            DONE: begin
                match_d = (err_q == '0);
                pqrs_d  = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.pqrs          = pqrs_q;
    assign bus.busy          = (state_q == DRIVE) || (state_q == SAMPLE);
    assign bus.done          = (state_q == DONE);
    assign bus.result        = result_q;
    assign bus.match         = match_q;
    assign bus.err_cnt       = err_q;
    assign bus.first_err_idx = ferr_q;
endmodule

// File: doc/sop_sweep_ctrl.md
# sop_sweep_ctrl

Self-checking sweep controller for the 4-input SOP function t = pq'r's + rs'. On a start pulse it drives all 16 {p,q,r,s} input combinations, in order, through a combinational evaluator. It captures each t into a 16-bit truth-table register and compares the result against an expected mask loaded at start. It sits between the lab top-level (switches/buttons) and the SOP evaluator, and owns all sequencing of that evaluator.

## Interface
- SETTLE, default 1: cycles each vector is held before t is sampled. Legal range 1..15.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle request; honoured only in IDLE
- exp_mask  in  16  expected truth table; bit i = t for {p,q,r,s}=i; sampled on accepted start
- pqrs  out  4  vector currently driven to the evaluator, {p,q,r,s}; reset 0
- busy  out  1  high in DRIVE and SAMPLE; reset 0
- done  out  1  one-cycle pulse in DONE; reset 0
- result  out  16  captured truth table; reset 0
- match  out  1  result == latched exp_mask; valid from done, held; reset 0
- err_cnt  out  5  number of mismatching vectors, 0..16; reset 0
- first_err_idx  out  4  lowest mismatching index; meaningful only when err_cnt != 0; reset 0

## Operation
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE, start=1: clear result, err_cnt, first_err_idx and match; latch exp_mask; set pqrs=0 and settle counter=0; go to DRIVE.
- IDLE, start=0: hold all outputs. Results from the last run remain readable.
- DRIVE: increment settle counter. Go to SAMPLE when counter reaches SETTLE-1, i.e. after SETTLE cycles in DRIVE.
- SAMPLE, one cycle:
  - result[pqrs] <= t.
  - If t != exp_mask[pqrs], increment err_cnt. If this is the first error, load first_err_idx <= pqrs.
  - If pqrs==15, go to DONE. Otherwise pqrs <= pqrs+1, counter <= 0, go to DRIVE.
- DONE, one cycle:
  - done=1; match <= (err_cnt==0), using the final count including vector 15.
  - Go to IDLE. pqrs returns to 0.
- start is ignored in DRIVE, SAMPLE and DONE. There is no queueing.
- pqrs is 4 bits and wraps 15→0 only via DONE→IDLE. It never increments past 15.
- err_cnt is 5 bits, so a full 16-vector mismatch (value 16) does not saturate or wrap.
- rst at any cycle, including mid-scan: next state IDLE, every output at its reset value, latched mask cleared.
- With the correct function, the golden mask is 16'h4644 (minterms 2, 6, 9, 10, 14).

## Timing
- Let E0 be the edge that accepts start.
- Vector k is driven from edge E0+k(SETTLE+1) and captured at edge E0+(k+1)(SETTLE+1).
- State is DONE and done=1 after edge E0+16(SETTLE+1). With SETTLE=1 this is edge E0+32.
- busy rises after E0 and falls when DONE is entered. busy and done are never high together.
- match, err_cnt, first_err_idx and result are stable from the done cycle until the next accepted start or rst.
- The evaluator path is purely combinational: pqrs → t within the same cycle.

## Structure
- Package sop_sweep_pkg holds:
  - the state enum (IDLE, DRIVE, SAMPLE, DONE);
  - NUM_VEC=16;
  - GOLDEN_MASK=16'h4644.
- Sub-module sop_eval (inputs p, q, r, s; output t) is the gate-level evaluator, instantiated once.
- The controller is a single FSM plus a settle counter, a vector counter and capture registers.

## Test plan
- Reset then idle: rst high 2 cycles, then start=0 for 10 cycles → all outputs 0, busy=0, pqrs=0.
- Golden sweep, SETTLE=1: start with exp_mask=16'h4644 → done after 32 edges, result=16'h4644, match=1, err_cnt=0.
- Mismatch: start with exp_mask=16'h4645 → result=16'h4644, match=0, err_cnt=1, first_err_idx=0. Then exp_mask=16'hB9BB → err_cnt=16, first_err_idx=0.
- Multiple errors: exp_mask=16'h0644 → err_cnt=1, first_err_idx=14. exp_mask=16'h4000 → err_cnt=4, first_err_idx=2.
- Start while busy, plus back-to-back runs:
  - pulse start mid-scan → ignored, done timing unchanged;
  - start in the cycle after done → new scan begins, outputs cleared.
- Reset mid-operation: assert rst at pqrs=7 in SAMPLE → next cycle IDLE, result=0, busy=0. A subsequent golden start completes normally. Repeat with SETTLE=3: done at edge E0+64.
